// File: rtl/tnn_pkg.sv
// Shared constants for the ternary neuron accumulator: ternary encodings,
// FSM state type and default widths.
package tnn_pkg;

   localparam int unsigned TNN_CNT_W     = 5;
   localparam int unsigned TNN_ACC_W     = 10;
   localparam int unsigned TNN_MAX_BEATS = 16;

   localparam logic [1:0] TNN_POS  = 2'b01;
   localparam logic [1:0] TNN_NEG  = 2'b11;
   localparam logic [1:0] TNN_ZERO = 2'b00;

   typedef enum logic {
      ACC = 1'b0,
      RES = 1'b1
   } tnn_state_e;

endpackage

// File: rtl/tnn_acc_add.sv
// Signed accumulator adder: ACC_W + D_W -> ACC_W. Wraps by default; with
// TNN_ACC_SAT_EN defined it clamps to the signed range and flags saturation.
module tnn_acc_add
   import tnn_pkg::*;
#(
   parameter int unsigned ACC_W = TNN_ACC_W,
   parameter int unsigned D_W   = TNN_CNT_W + 1
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [D_W-1:0]   delta_i,
   output logic [ACC_W-1:0] sum_c,
   output logic             sat_c
);

`ifdef TNN_ACC_SAT_EN
   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] wide_c;
   logic                  ovf_c;

   // One guard bit: overflow shows as disagreement of the top two bits.
   assign wide_c = (ACC_W+1)'($signed(acc_i)) + (ACC_W+1)'($signed(delta_i));
   assign ovf_c  = wide_c[ACC_W] ^ wide_c[ACC_W-1];
   assign sum_c  = ovf_c ? (wide_c[ACC_W] ? MIN_V : MAX_V) : wide_c[ACC_W-1:0];
   assign sat_c  = ovf_c;
`else
   assign sum_c = acc_i + ACC_W'($signed(delta_i));
   assign sat_c = 1'b0;
`endif

endmodule

// File: rtl/tnn_neuron_accum.sv
// Ternary neuron accumulator: sums pos-neg popcount beats, applies a dual
// threshold at end of neuron. Optional saturation via TNN_ACC_SAT_EN.
module tnn_neuron_accum
   import tnn_pkg::*;
#(
   parameter int unsigned CNT_W     = TNN_CNT_W,
   parameter int unsigned ACC_W     = TNN_ACC_W,
   parameter int unsigned MAX_BEATS = TNN_MAX_BEATS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CNT_W-1:0] in_pos,
   input  logic [CNT_W-1:0] in_neg,
   input  logic             in_last,
   input  logic [ACC_W-1:0] thr_lo,
   input  logic [ACC_W-1:0] thr_hi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_trunc
);

   localparam int unsigned     D_W      = CNT_W + 1;
   localparam int unsigned     BC_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [BC_W-1:0] LAST_CNT = BC_W'(MAX_BEATS - 1);

   tnn_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [BC_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0] thr_lo_q, thr_lo_d;
   logic [ACC_W-1:0] thr_hi_q, thr_hi_d;
   logic             sat_q, sat_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       act_q, act_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             trunc_q, trunc_d;

   logic [D_W-1:0]   delta_c;
   logic             first_c;
   logic [ACC_W-1:0] add_a_c;
   logic [ACC_W-1:0] add_sum_c;
   logic             add_sat_c;
   logic [ACC_W-1:0] thr_lo_c;
   logic [ACC_W-1:0] thr_hi_c;
   logic [1:0]       act_c;

   assign delta_c = D_W'(in_pos) - D_W'(in_neg);
   assign first_c = (cnt_q == '0);
   assign add_a_c = first_c ? '0 : acc_q;

   tnn_acc_add #(
      .ACC_W (ACC_W),
      .D_W   (D_W)
   ) u_add (
      .acc_i   (add_a_c),
      .delta_i (delta_c),
      .sum_c   (add_sum_c),
      .sat_c   (add_sat_c)
   );

   // First beat classifies against live thresholds (they are only latched now).
   assign thr_lo_c = first_c ? thr_lo : thr_lo_q;
   assign thr_hi_c = first_c ? thr_hi : thr_hi_q;
   assign act_c    = ($signed(add_sum_c) > $signed(thr_hi_c)) ? TNN_POS  :
                     ($signed(add_sum_c) < $signed(thr_lo_c)) ? TNN_NEG  :
                                                                TNN_ZERO;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      thr_lo_d    = thr_lo_q;
      thr_hi_d    = thr_hi_q;
      sat_d       = sat_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      act_d       = act_q;
      sum_d       = sum_q;
      trunc_d     = trunc_q;
      case (state_q)
         ACC: begin
            if (in_valid && in_ready_q) begin
               if (first_c) begin
                  thr_lo_d = thr_lo;
                  thr_hi_d = thr_hi;
               end
               if (in_last || (cnt_q == LAST_CNT)) begin
                  sum_d       = add_sum_c;
                  act_d       = act_c;
                  trunc_d     = ~in_last | sat_q | add_sat_c;
                  acc_d       = '0;
                  cnt_d       = '0;
                  sat_d       = 1'b0;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = RES;
               end else begin
                  acc_d = add_sum_c;
                  cnt_d = cnt_q + BC_W'(1);
                  sat_d = sat_q | add_sat_c;
               end
            end
         end
         RES: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         thr_lo_q    <= '0;
         thr_hi_q    <= '0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         act_q       <= TNN_ZERO;
         sum_q       <= '0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         thr_lo_q    <= thr_lo_d;
         thr_hi_q    <= thr_hi_d;
         sat_q       <= sat_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         act_q       <= act_d;
         sum_q       <= sum_d;
         trunc_q     <= trunc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_act   = act_q;
   assign out_sum   = sum_q;
   assign out_trunc = trunc_q;

endmodule

// File: doc/tnn_neuron_accum.md
Name: tnn_neuron_accum

Overview:
- Sequential stage directly downstream of the popcount21 approximate popcount instances in a ternary neuron.
- Per input beat, consumes two 5-bit counts from the upstream popcount pair:
  - positive-weight matches
  - negative-weight matches
- Accumulates the signed difference across a multi-beat (time-multiplexed) fan-in.
- At end of the neuron, applies a dual threshold and emits a ternary activation plus the raw sum, via valid/ready handshakes.

Parameters:
- CNT_W, 5: width of each popcount input.
- ACC_W, 10: signed accumulator and threshold width.
- MAX_BEATS, 16: maximum beats per neuron; forced termination when reached.

Ports:
- clk        in   1       clock; single domain.
- rst        in   1       synchronous, active-high reset.
- in_valid   in   1       beat valid.
- in_ready   out  1       stage can accept a beat.
- in_pos     in   CNT_W   popcount of positive-weight matches.
- in_neg     in   CNT_W   popcount of negative-weight matches.
- in_last    in   1       final beat of this neuron.
- thr_lo     in   ACC_W   signed lower threshold.
- thr_hi     in   ACC_W   signed upper threshold.
- out_valid  out  1       result valid.
- out_ready  in   1       downstream accepts the result.
- out_act    out  2       ternary activation: 01 = +1, 11 = -1, 00 = 0.
- out_sum    out  ACC_W   signed final sum.
- out_trunc  out  1       neuron was cut at MAX_BEATS without in_last.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-neuron):
  - state=ACC; acc=0; beat_cnt=0.
  - out_valid=0, out_act=00, out_sum=0, out_trunc=0.
  - Partial accumulation is discarded.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- State ACC:
  - in_ready=1, out_valid=0.
  - delta = zero-extend(in_pos) - zero-extend(in_neg), computed at CNT_W+1 bits signed, then sign-extended to ACC_W.
  - First beat (beat_cnt==0): acc_next = delta, and thr_lo/thr_hi are sampled into registers. Later beats: acc_next = acc + delta.
  - End of neuron: accepted beat with in_last=1, or beat_cnt==MAX_BEATS-1.
  - On an end beat:
    - out_sum <= acc_next.
    - out_trunc <= (in_last==0).
    - out_act <= 01 if acc_next > thr_hi_reg; else 11 if acc_next < thr_lo_reg; else 00. The +1 check takes priority when thr_lo > thr_hi.
    - acc=0, beat_cnt=0, state -> RES.
  - On a non-end beat: acc <= acc_next, beat_cnt++.
- Latency: out_valid rises the cycle after the end beat is accepted.
- State RES:
  - in_ready=0; out_valid=1; outputs held stable.
  - When out_ready=1: state -> ACC and out_valid=0 next cycle.
  - Throughput is one bubble cycle per neuron.
- Threshold changes after the first beat have no effect on the current neuron.
- Idle: in_valid=0 in ACC holds all state.
- Overflow without the macro: two's-complement wrap at ACC_W. Default sizing (16×31 = 496) cannot overflow.

Optional Feature:
- Macro: TNN_ACC_SAT_EN.
- Defined: accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is sticky within a neuron and is reported via the existing out_trunc bit OR'd with a saturation flag.
- Not defined: plain wrap; out_trunc reflects only beat truncation.

Decomposition:
- Package tnn_pkg:
  - Ternary encoding constants TNN_POS=2'b01, TNN_NEG=2'b11, TNN_ZERO=2'b00.
  - State enum {ACC, RES}.
  - Default ACC_W/CNT_W localparams.
- Sub-module tnn_acc_add: signed adder, ACC_W + (CNT_W+1) -> ACC_W. Wraps, or saturates under TNN_ACC_SAT_EN; outputs sum and sat flag.

Test Plan:
- Single beat pos=21, neg=3, last=1, thr_lo=-5, thr_hi=10 -> next cycle out_valid=1, out_sum=18, out_act=01, out_trunc=0.
- Three beats (5,9),(2,8),(0,4), last on the third, thr_lo=-5, thr_hi=5 -> out_sum=-14, out_act=11; in_ready=0 while out_ready=0 held for 4 cycles; outputs stable throughout.
- 16 beats of (31,0) with no last, thr_hi=0 -> result after beat 16: out_sum=496, out_trunc=1, out_act=01; next beat starts from acc=0.
- thr_lo=3, thr_hi=3, beats summing to exactly 3 -> out_act=00. thr_hi changed to -100 after the first beat -> no effect.
- rst=1 after two accepted beats (sum 20), then single beat (1,1,last) -> out_sum=0, out_act=00; no stale accumulation.
- With TNN_ACC_SAT_EN, ACC_W=6: beats (31,0),(31,0),last -> out_sum=31 (saturated), out_trunc=1. Without the macro -> wrapped sum -2.
